// File: rtl/vout_frame_reader_ctrl.sv
// vout_frame_reader_ctrl: reads the most recently completed frame from external memory into the video-out FIFO using length-limited bursts; optional VOUT_RD_VFLIP_EN enables bottom-up line order
module vout_frame_reader_ctrl #(
    parameter int MEM_DATA_BITS  = 64,
    parameter int PIXEL_BITS     = 16,
    parameter int BURST_LEN      = 128,
    parameter int ADDR_BITS      = 27,
    parameter int FRAME_IDX_BITS = 2,
    parameter int FRAME_SHIFT    = 23,
    parameter int FIFO_DEPTH     = 256,
    parameter int WAIT_CYCLES    = 2000
) (
    input  logic                           mem_clk,
    input  logic                           rst,
    input  logic                           frame_start,
    input  logic [11:0]                    vout_width,
    input  logic [11:0]                    vout_height,
    input  logic [ADDR_BITS-1:0]           line_stride,
    input  logic [ADDR_BITS-1:0]           base_addr,
    input  logic                           wr_done,
    input  logic [FRAME_IDX_BITS-1:0]      wr_frame_idx,
    input  logic                           vflip,
    input  logic [$clog2(FIFO_DEPTH)-1:0]  fifo_wrusedw,
    output logic                           fifo_clr,
    output logic                           fifo_wr_en,
    output logic [MEM_DATA_BITS-1:0]       fifo_wr_data,
    output logic                           rd_burst_req,
    output logic [9:0]                     rd_burst_len,
    output logic [ADDR_BITS-1:0]           rd_burst_addr,
    input  logic                           rd_burst_data_valid,
    input  logic [MEM_DATA_BITS-1:0]       rd_burst_data,
    input  logic                           burst_finish,
    output logic                           frame_busy,
    output logic                           frame_done
);
    localparam int PPW     = MEM_DATA_BITS / PIXEL_BITS;
    localparam int PPW_LOG = $clog2(PPW);
    localparam int WB_LOG  = $clog2(MEM_DATA_BITS / 8);
    localparam int FAW     = $clog2(FIFO_DEPTH);
    localparam int WCW     = $clog2(WAIT_CYCLES + 1);
    localparam logic [FAW-1:0] FIFO_TH   = FAW'(FIFO_DEPTH - 1 - BURST_LEN);
    localparam logic [11:0]    BLEN      = 12'(BURST_LEN);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LINE_START, S_REQ, S_BURSTING, S_LINE_END, S_DONE} state_t;

    state_t                    state, state_d;
    logic [FRAME_IDX_BITS-1:0] latest_idx, rd_frame_idx, sel_idx;
    logic [11:0]               width_q, height_q, line_cnt, remain, wpl, len_next;
    logic [ADDR_BITS-1:0]      stride_q, base_q, line_addr, burst_offset, flip_acc, frame_base;
    logic [WCW-1:0]            wait_cnt;
    logic                      discard, space, wait_done, flip_done, down, last_line;

    assign sel_idx      = wr_done ? wr_frame_idx : latest_idx;
    assign frame_base   = base_q + (ADDR_BITS'(rd_frame_idx) << FRAME_SHIFT);
    assign wpl          = 12'((13'(width_q) + 13'(PPW - 1)) >> PPW_LOG);
    assign len_next     = remain > BLEN ? BLEN : remain;
    assign space        = fifo_wrusedw <= FIFO_TH;
    assign wait_done    = wait_cnt == WAIT_LAST;
    assign last_line    = line_cnt + 12'd1 == height_q;
    assign fifo_wr_en   = rd_burst_data_valid & ~discard;
    assign fifo_wr_data = rd_burst_data;
    assign frame_busy   = state != S_IDLE && state != S_DONE;

`ifdef VOUT_RD_VFLIP_EN
    logic        vflip_q;
    logic [11:0] flip_cnt;
    assign flip_done = ~vflip_q || height_q == 12'd0 || flip_cnt == height_q - 12'd1;
    assign down      = vflip_q;
    // Latch the flip request and count stride additions toward the bottom-line address
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            vflip_q  <= 1'b0;
            flip_cnt <= '0;
        end else if (frame_start) begin
            vflip_q  <= vflip;
            flip_cnt <= '0;
        end else if (state == S_WAIT && !flip_done) begin
            flip_cnt <= flip_cnt + 12'd1;
        end
    end
`else
    logic unused_vflip;
    assign unused_vflip = vflip;
    assign flip_done    = 1'b1;
    assign down         = 1'b0;
`endif

    // State register
    always_ff @(posedge mem_clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // Next-state logic; frame_start restarts the frame from any state
    always_comb begin
        state_d = state;
        case (state)
            S_WAIT:       if (wait_done && flip_done) state_d = (width_q == 12'd0 || height_q == 12'd0) ? S_DONE : S_LINE_START;
            S_LINE_START: state_d = S_REQ;
            S_REQ:        if (space && !discard) state_d = S_BURSTING;
            S_BURSTING:   if (burst_finish) state_d = remain == 12'(rd_burst_len) ? S_LINE_END : S_REQ;
            S_LINE_END:   state_d = last_line ? S_DONE : S_LINE_START;
            default:      ;
        endcase
        if (frame_start) state_d = S_WAIT;
    end

    // Frame selection, configuration capture, address generation and burst handshake
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            fifo_clr      <= 1'b0;
            frame_done    <= 1'b0;
            rd_burst_req  <= 1'b0;
            rd_burst_len  <= '0;
            rd_burst_addr <= '0;
            latest_idx    <= '0;
            rd_frame_idx  <= '0;
            width_q       <= '0;
            height_q      <= '0;
            stride_q      <= '0;
            base_q        <= '0;
            line_cnt      <= '0;
            line_addr     <= '0;
            burst_offset  <= '0;
            flip_acc      <= '0;
            remain        <= '0;
            wait_cnt      <= '0;
            discard       <= 1'b0;
        end else begin
            fifo_clr   <= frame_start;
            frame_done <= 1'b0;
            if (wr_done) latest_idx <= wr_frame_idx;
            if (burst_finish) discard <= 1'b0;
            if (frame_start) begin
                rd_frame_idx <= sel_idx;
                width_q      <= vout_width;
                height_q     <= vout_height;
                stride_q     <= line_stride;
                base_q       <= base_addr;
                line_cnt     <= '0;
                wait_cnt     <= '0;
                flip_acc     <= '0;
                rd_burst_req <= 1'b0;
                discard      <= state == S_BURSTING && !burst_finish;
            end else begin
                case (state)
                    S_WAIT: begin
                        line_addr <= frame_base + flip_acc;
                        if (!wait_done) wait_cnt <= wait_cnt + 1'b1;
                        if (!flip_done) flip_acc <= flip_acc + stride_q;
                    end
                    S_LINE_START: begin
                        remain       <= wpl;
                        burst_offset <= '0;
                    end
                    S_REQ: if (space && !discard) begin
                        rd_burst_req  <= 1'b1;
                        rd_burst_len  <= 10'(len_next);
                        rd_burst_addr <= line_addr + burst_offset;
                    end
                    S_BURSTING: begin
                        if (rd_burst_data_valid || burst_finish) rd_burst_req <= 1'b0;
                        if (burst_finish) begin
                            remain       <= remain - 12'(rd_burst_len);
                            burst_offset <= burst_offset + (ADDR_BITS'(rd_burst_len) << WB_LOG);
                        end
                    end
                    S_LINE_END: begin
                        line_cnt   <= line_cnt + 12'd1;
                        line_addr  <= down ? line_addr - stride_q : line_addr + stride_q;
                        frame_done <= last_line;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vout_frame_reader_ctrl.sv
// tb_vout_frame_reader_ctrl: randomized bench with an arbiter model and a frame-level burst/data reference model
module tb_vout_frame_reader_ctrl;
    localparam int WC = 40;
`ifdef VOUT_RD_VFLIP_EN
    localparam bit FLIP_ON = 1'b1;
`else
    localparam bit FLIP_ON = 1'b0;
`endif

    logic        mem_clk = 1'b0, rst = 1'b1, frame_start = 1'b0, wr_done = 1'b0, vflip = 1'b0;
    logic [11:0] vout_width = '0, vout_height = '0;
    logic [26:0] line_stride = '0, base_addr = '0;
    logic [1:0]  wr_frame_idx = '0;
    logic [7:0]  fifo_wrusedw = '0;
    logic        fifo_clr, fifo_wr_en, rd_burst_req, frame_busy, frame_done;
    logic [63:0] fifo_wr_data, rd_burst_data = '0;
    logic [9:0]  rd_burst_len;
    logic [26:0] rd_burst_addr;
    logic        rd_burst_data_valid = 1'b0, burst_finish = 1'b0;

    int n_cmp = 0, n_bad = 0;
    int done_cnt = 0, clr_cnt = 0, frame_d0 = 0, frame_c0 = 0, model_latest = 0;
    bit arb_busy = 1'b0;
    logic [26:0] obs_addr[$], exp_addr[$];
    int          obs_len[$], exp_len[$];
    logic [63:0] wr_q[$];

    vout_frame_reader_ctrl #(.WAIT_CYCLES(WC)) dut (
        .mem_clk(mem_clk), .rst(rst), .frame_start(frame_start),
        .vout_width(vout_width), .vout_height(vout_height),
        .line_stride(line_stride), .base_addr(base_addr),
        .wr_done(wr_done), .wr_frame_idx(wr_frame_idx), .vflip(vflip),
        .fifo_wrusedw(fifo_wrusedw), .fifo_clr(fifo_clr), .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data), .rd_burst_req(rd_burst_req),
        .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
        .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
        .burst_finish(burst_finish), .frame_busy(frame_busy), .frame_done(frame_done)
    );

    always #5 mem_clk = ~mem_clk;

    function automatic logic [63:0] pat(input logic [26:0] a);
        return {5'h15, a, ~a, 5'h0A};
    endfunction

    // Memory arbiter model: accepts a request, returns len beats with random gaps, then burst_finish
    initial begin
        forever begin
            @(negedge mem_clk);
            if (rd_burst_req === 1'b1) begin
                logic [26:0] a;
                int n;
                a = rd_burst_addr;
                n = int'(rd_burst_len);
                obs_addr.push_back(a);
                obs_len.push_back(n);
                arb_busy = 1'b1;
                repeat ($urandom_range(0, 3)) @(negedge mem_clk);
                for (int k = 0; k < n; k++) begin
                    rd_burst_data_valid = 1'b1;
                    rd_burst_data = pat(a + 27'(k * 8));
                    @(negedge mem_clk);
                    rd_burst_data_valid = 1'b0;
                    if ($urandom_range(0, 3) == 0) @(negedge mem_clk);
                end
                burst_finish = 1'b1;
                @(negedge mem_clk);
                burst_finish = 1'b0;
                arb_busy = 1'b0;
            end
        end
    end

    // Output monitor, sampling between the falling and rising edges
    initial begin
        forever begin
            @(negedge mem_clk);
            #2;
            if (fifo_wr_en === 1'b1) wr_q.push_back(fifo_wr_data);
            if (frame_done === 1'b1) done_cnt++;
            if (fifo_clr === 1'b1) clr_cnt++;
        end
    end

    // Reference model: every line address and its split into bursts of at most 128 words
    task automatic build_exp(input int w, input int h, input logic [26:0] s, input logic [26:0] b, input int idx, input bit fl);
        exp_addr.delete();
        exp_len.delete();
        for (int l = 0; l < h; l++) begin
            longint la, off;
            int words, n;
            la = longint'(b) + (longint'(idx) << 23) + longint'(fl ? h - 1 - l : l) * longint'(s);
            words = (w + 3) / 4;
            off = 0;
            while (words > 0) begin
                n = words > 128 ? 128 : words;
                exp_addr.push_back(27'(la + off));
                exp_len.push_back(n);
                off += n * 8;
                words -= n;
            end
        end
    endtask

    task automatic start_frame(input int w, input int h, input logic [26:0] s, input logic [26:0] b, input bit bypass, input int bidx, input bit fl);
        @(negedge mem_clk);
        vout_width = 12'(w);
        vout_height = 12'(h);
        line_stride = s;
        base_addr = b;
        vflip = fl;
        if (bypass) model_latest = bidx;
        build_exp(w, h, s, b, model_latest, fl && FLIP_ON);
        obs_addr.delete();
        obs_len.delete();
        wr_q.delete();
        frame_d0 = done_cnt;
        frame_c0 = clr_cnt;
        frame_start = 1'b1;
        wr_done = bypass;
        wr_frame_idx = 2'(bidx);
        @(negedge mem_clk);
        frame_start = 1'b0;
        wr_done = 1'b0;
    endtask

    task automatic wait_frame(input string name, input bit expect_done);
        int t = 0;
        while ((expect_done ? done_cnt == frame_d0 : frame_busy !== 1'b0) && t <= 30000) begin
            @(negedge mem_clk);
            #2;
            t++;
        end
        n_cmp++;
        if (t > 30000) begin
            n_bad++;
            $display("FAIL %s timeout: frame end not seen after %0d cycles", name, t);
        end
    endtask

    task automatic compare_frame(input string name, input int exp_done);
        int total = 0, bad = 0, j = 0, first = -1;
        repeat (2) @(negedge mem_clk);
        #2;
        n_cmp++;
        if (done_cnt - frame_d0 !== exp_done) begin
            n_bad++;
            $display("FAIL %s frame_done pulses: got %0d want %0d", name, done_cnt - frame_d0, exp_done);
        end
        n_cmp++;
        if (clr_cnt - frame_c0 !== 1) begin
            n_bad++;
            $display("FAIL %s fifo_clr pulses: got %0d want 1", name, clr_cnt - frame_c0);
        end
        n_cmp++;
        if (frame_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s frame_busy after frame: got %b want 0", name, frame_busy);
        end
        n_cmp++;
        if (obs_addr.size() != exp_addr.size()) begin
            n_bad++;
            $display("FAIL %s burst count: got %0d want %0d", name, obs_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            n_cmp++;
            if (obs_addr[i] !== exp_addr[i] || obs_len[i] !== exp_len[i]) begin
                n_bad++;
                $display("FAIL %s burst %0d: got (%0d,%0d) want (%0d,%0d)", name, i, obs_addr[i], obs_len[i], exp_addr[i], exp_len[i]);
            end
        end
        foreach (exp_len[i]) total += exp_len[i];
        n_cmp++;
        if (wr_q.size() != total) begin
            n_bad++;
            $display("FAIL %s fifo writes: got %0d want %0d", name, wr_q.size(), total);
        end
        foreach (exp_addr[i]) begin
            for (int k = 0; k < exp_len[i]; k++) begin
                if (j < wr_q.size() && wr_q[j] !== pat(exp_addr[i] + 27'(k * 8))) begin
                    bad++;
                    if (first < 0) first = j;
                end
                j++;
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s fifo data: %0d beats wrong, first at beat %0d got %h", name, bad, first, wr_q[first]);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge mem_clk);
        #2;
        n_cmp++;
        if ({fifo_clr, fifo_wr_en, rd_burst_req, frame_busy, frame_done} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset flags: got %b want 00000", {fifo_clr, fifo_wr_en, rd_burst_req, frame_busy, frame_done});
        end
        n_cmp++;
        if (rd_burst_len !== 10'd0 || rd_burst_addr !== 27'd0) begin
            n_bad++;
            $display("FAIL reset burst: got len %0d addr %0d want 0 0", rd_burst_len, rd_burst_addr);
        end
        @(negedge mem_clk);
        rst = 1'b0;
    endtask

    task automatic test_line_split;
        start_frame(1920, 2, 27'd4096, 27'd0, 1'b0, 0, 1'b0);
        wait_frame("line_split", 1'b1);
        compare_frame("line_split", 1);
    endtask

    task automatic test_rounding;
        start_frame(201, 1, 27'd4096, 27'd0, 1'b0, 0, 1'b0);
        wait_frame("rounding", 1'b1);
        compare_frame("rounding", 1);
    endtask

    task automatic test_frame_select;
        @(negedge mem_clk);
        wr_done = 1'b1;
        wr_frame_idx = 2'd3;
        model_latest = 3;
        @(negedge mem_clk);
        wr_done = 1'b0;
        start_frame(16, 1, 27'd4096, 27'h100, 1'b0, 0, 1'b0);
        wait_frame("select_latched", 1'b1);
        compare_frame("select_latched", 1);
        start_frame(16, 2, 27'd4096, 27'h100, 1'b1, 2, 1'b0);
        wait_frame("select_bypass", 1'b1);
        compare_frame("select_bypass", 1);
    endtask

    task automatic test_backpressure;
        fifo_wrusedw = 8'd200;
        start_frame(8, 1, 27'd64, 27'd0, 1'b0, 0, 1'b0);
        repeat (WC + 10) @(negedge mem_clk);
        #2;
        n_cmp++;
        if (rd_burst_req !== 1'b0 || obs_addr.size() != 0) begin
            n_bad++;
            $display("FAIL backpressure_200: got req %b bursts %0d want 0 0", rd_burst_req, obs_addr.size());
        end
        @(negedge mem_clk);
        fifo_wrusedw = 8'd128;
        repeat (5) @(negedge mem_clk);
        #2;
        n_cmp++;
        if (rd_burst_req !== 1'b0 || obs_addr.size() != 0) begin
            n_bad++;
            $display("FAIL backpressure_128: got req %b bursts %0d want 0 0", rd_burst_req, obs_addr.size());
        end
        @(negedge mem_clk);
        fifo_wrusedw = 8'd127;
        @(negedge mem_clk);
        #2;
        n_cmp++;
        if (rd_burst_req !== 1'b1) begin
            n_bad++;
            $display("FAIL backpressure_release: got req %b want 1", rd_burst_req);
        end
        wait_frame("backpressure", 1'b1);
        compare_frame("backpressure", 1);
        fifo_wrusedw = 8'd0;
    endtask

    task automatic test_restart;
        int t = 0;
        start_frame(1920, 2, 27'd4096, 27'd0, 1'b0, 0, 1'b0);
        while (!(obs_addr.size() >= 2 && rd_burst_data_valid === 1'b1) && t < 5000) begin
            @(negedge mem_clk);
            #2;
            t++;
        end
        n_cmp++;
        if (t >= 5000) begin
            n_bad++;
            $display("FAIL restart setup timeout: bursts %0d", obs_addr.size());
        end
        start_frame(1920, 2, 27'd4096, 27'd0, 1'b0, 0, 1'b0);
        #3;
        wr_q.delete();
        t = 0;
        while (arb_busy && t < 2000) begin
            @(negedge mem_clk);
            #2;
            t++;
        end
        n_cmp++;
        if (wr_q.size() != 0 || arb_busy) begin
            n_bad++;
            $display("FAIL restart discard: got %0d writes from aborted burst want 0", wr_q.size());
        end
        wait_frame("restart", 1'b1);
        compare_frame("restart", 1);
    endtask

    task automatic test_zero_size;
        start_frame(16, 0, 27'd4096, 27'd0, 1'b0, 0, 1'b0);
        wait_frame("zero_height", 1'b0);
        compare_frame("zero_height", 0);
        start_frame(0, 2, 27'd4096, 27'd0, 1'b0, 0, 1'b0);
        wait_frame("zero_width", 1'b0);
        compare_frame("zero_width", 0);
    endtask

    task automatic test_random;
        for (int r = 0; r < 6; r++) begin
            int w, h, idx;
            bit byp, fl;
            w = $urandom_range(1, 1400);
            h = $urandom_range(1, 3);
            idx = $urandom_range(0, 3);
            byp = 1'($urandom_range(0, 1));
            fl = 1'($urandom_range(0, 1));
            fifo_wrusedw = 8'($urandom_range(0, 127));
            if (!byp) begin
                @(negedge mem_clk);
                wr_done = 1'b1;
                wr_frame_idx = 2'(idx);
                model_latest = idx;
                @(negedge mem_clk);
                wr_done = 1'b0;
            end
            start_frame(w, h, 27'($urandom), 27'($urandom), byp, idx, fl);
            wait_frame("random", 1'b1);
            compare_frame("random", 1);
        end
        fifo_wrusedw = 8'd0;
    endtask

`ifdef VOUT_RD_VFLIP_EN
    task automatic test_vflip;
        start_frame(4, 3, 27'd4096, 27'd0, 1'b1, 0, 1'b1);
        wait_frame("vflip", 1'b1);
        compare_frame("vflip", 1);
    endtask
`endif

    initial begin
        test_reset();
        test_line_split();
        test_rounding();
        test_frame_select();
        test_backpressure();
        test_restart();
        test_zero_size();
        test_random();
`ifdef VOUT_RD_VFLIP_EN
        test_vflip();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
